// File: rtl/word_packer.sv
// word_packer: packs RATIO consecutive DATA_W-bit words into one wide word.
//   clock/reset        : 1x datapath clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake; in_data is one word, in_last ends a burst
//   out_valid/out_ready: output handshake; out_data packs slot k at [k*DATA_W +: DATA_W]
//   out_count/out_last : number of valid slots (1..RATIO) and burst-end flag
module word_packer #(
    parameter int DATA_W = 16,
    parameter int RATIO  = 5,
    parameter int CNT_W  = $clog2(RATIO + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RATIO*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]          out_count,
    output logic                      out_last
);
    logic [CNT_W-1:0]        idx_q, idx_d, pcnt_q, pcnt_d, ocnt_q, ocnt_d;
    logic [RATIO*DATA_W-1:0] fill_q, fill_d, fill_w, odata_q, odata_d;
    logic                    pend_q, pend_d, plast_q, plast_d, ovalid_q, ovalid_d, olast_q, olast_d;
    logic                    accept, close, free, load;

    assign in_ready  = ~pend_q & ~reset;
    assign out_valid = ovalid_q;
    assign out_data  = odata_q;
    assign out_count = ocnt_q;
    assign out_last  = olast_q;

    always_comb begin
        accept = in_valid & in_ready;
        fill_w = fill_q;
        if (accept) fill_w[idx_q*DATA_W +: DATA_W] = in_data;
        close = accept & ((idx_q == CNT_W'(RATIO - 1)) | in_last);
        free  = ~ovalid_q | out_ready;
        // a parked word has priority; in_ready is low while it waits
        load  = pend_q ? free : (close & free);
        idx_d    = idx_q;
        fill_d   = fill_q;
        pend_d   = pend_q;
        pcnt_d   = pcnt_q;
        plast_d  = plast_q;
        ovalid_d = ovalid_q & ~out_ready;
        odata_d  = odata_q;
        ocnt_d   = ocnt_q;
        olast_d  = olast_q;
        if (load) begin
            ovalid_d = 1'b1;
            odata_d  = pend_q ? fill_q : fill_w;
            ocnt_d   = pend_q ? pcnt_q : idx_q + CNT_W'(1);
            olast_d  = pend_q ? plast_q : in_last;
            fill_d   = '0;
            idx_d    = '0;
            pend_d   = 1'b0;
        end else if (close) begin
            // output busy: park the closed word in the fill register
            pend_d  = 1'b1;
            fill_d  = fill_w;
            pcnt_d  = idx_q + CNT_W'(1);
            plast_d = in_last;
            idx_d   = '0;
        end else if (accept) begin
            fill_d = fill_w;
            idx_d  = idx_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q    <= '0;
            fill_q   <= '0;
            pend_q   <= 1'b0;
            pcnt_q   <= '0;
            plast_q  <= 1'b0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            ocnt_q   <= '0;
            olast_q  <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            fill_q   <= fill_d;
            pend_q   <= pend_d;
            pcnt_q   <= pcnt_d;
            plast_q  <= plast_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            ocnt_q   <= ocnt_d;
            olast_q  <= olast_d;
        end
    end
endmodule
